acc_iq_avg_ss_ctrl: RTL and testbench
=====================================

# acc_iq_avg_ss_ctrl

Snapshot capture controller for the averaged-IQ stream. It packs each valid averaged I/Q sample pair into a 32-bit word and writes a software-armed, trigger-started burst of up to 1024 words into port A of the snapshot BRAM. That BRAM's port B is read over the processor bus. The block sits directly between the IQ averager output and the snapshot BRAM, and exposes busy/done/count status to software registers.

## Interface
- ADDR_WIDTH, 10, BRAM word-address width; depth = 2^ADDR_WIDTH = 1024 words.
- SAMP_WIDTH, 16, width of each of I and Q; BRAM word = 2*SAMP_WIDTH = 32.
- clk  in  1  single fabric clock; the BRAM port-A clock is the same net.
- rst  in  1  synchronous, active-high reset.
- arm  in  1  software register bit, level; a rising edge arms the capture.
- trig  in  1  capture trigger, level, sampled only while armed.
- num_words  in  ADDR_WIDTH+1  capture length 1..1024; 0 and values >1024 mean 1024; latched on the arm edge.
- din_i  in  SAMP_WIDTH  averaged I sample, two's complement.
- din_q  in  SAMP_WIDTH  averaged Q sample, two's complement.
- din_valid  in  1  qualifies din_i/din_q.
- bram_we  out  1  port-A write enable.
- bram_en_a  out  1  port-A enable; equals bram_we.
- bram_addr  out  ADDR_WIDTH  port-A word address.
- bram_wr_data  out  2*SAMP_WIDTH  packed word {din_i, din_q}; I in [31:16], Q in [15:0].
- busy  out  1  high in ARMED or CAPTURE.
- done  out  1  high in DONE.
- count  out  ADDR_WIDTH+1  number of words written in the current or last capture.

## Operation
- Arm edge detect: internal arm_d register; arm_pulse = arm & ~arm_d. arm_d resets to 0, so arm held high through reset release gives a pulse on the first cycle after reset.
- FSM states IDLE, ARMED, CAPTURE, DONE. Reset state is IDLE.
- IDLE: on arm_pulse, latch the length into len_r, clear count, go to ARMED. trig is ignored in IDLE, even when it coincides with arm_pulse.
- ARMED: wait for trig & din_valid in the same cycle. That sample is word 0: write it at address 0, set count = 1, go to CAPTURE. If len_r == 1, go to DONE instead. trig without din_valid does not start the capture.
- CAPTURE: each din_valid writes the word at address count, then count increments. When count reaches len_r, go to DONE. trig is ignored. Gaps in din_valid stall the capture without bound.
- DONE: done = 1, no writes. On arm_pulse, clear count, latch the new length, go to ARMED (done drops).
- arm_pulse in ARMED or CAPTURE is ignored.
- Addresses are 0..len_r-1 with no wrap. The address never exceeds 1023, and count never exceeds 1024.
- Writes occur only in the trigger cycle (ARMED) and in CAPTURE. No other state ever asserts bram_we.

## Timing
- All outputs are registered. Reset values: bram_we = 0, bram_en_a = 0, bram_addr = 0, bram_wr_data = 0, busy = 0, done = 0, count = 0.
- Write latency is 1 cycle. A sample accepted at clock edge N appears on bram_we/addr/data during cycle N+1 and is written to the BRAM at edge N+1.
- bram_addr and bram_wr_data hold their last value while bram_we = 0.
- count updates in the same cycle as the bram_we of the word it counts. done rises in the cycle after the last bram_we.
- busy rises in the cycle after arm_pulse. busy falls in the same cycle done rises.
- Throughput is one word per clock with din_valid continuously high. A 1024-word capture takes 1024 cycles from trigger to the last write.
- rst mid-capture: next cycle all outputs return to reset values and the FSM returns to IDLE. Written BRAM contents are left as-is. A new arm edge is required to capture again.

## Test plan
- Basic: num_words = 8, arm edge, trig with din_valid high, I = k, Q = -k for k = 0..7 -> addresses 0..7 hold {k, -k}; count = 8; done rises 1 cycle after the 8th write; bram_we high for exactly 8 cycles.
- Full/zero length: num_words = 0, continuous valid -> 1024 writes at addresses 0..1023; count = 1024; no write after address 1023; done = 1.
- Gapped valid: din_valid high on alternate cycles, num_words = 4 -> 4 writes at consecutive addresses 0..3; busy stays high through the gaps; count tracks each write.
- Trigger qualification: trig high without din_valid in ARMED -> no write; trig held during IDLE together with the arm edge -> no capture until trig is sampled in ARMED; arm edges during CAPTURE -> no restart and no change to len_r.
- Re-arm: after DONE, a new arm edge with num_words = 2 -> done drops, count = 0, the next capture overwrites addresses 0..1 only, count = 2.
- Reset mid-capture: assert rst after 5 of 16 words -> all outputs are 0 the next cycle; no further writes; a subsequent arm and trig restarts at address 0.

Source files
------------

// File: rtl/acc_iq_avg_ss_ctrl.sv
// Snapshot capture controller: packs averaged I/Q pairs into 32-bit words and
// writes an armed, trigger-started burst into port A of the snapshot BRAM.
module acc_iq_avg_ss_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int SAMP_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    arm,
  input  logic                    trig,
  input  logic [ADDR_WIDTH:0]     num_words,
  input  logic [SAMP_WIDTH-1:0]   din_i,
  input  logic [SAMP_WIDTH-1:0]   din_q,
  input  logic                    din_valid,
  output logic                    bram_we,
  output logic                    bram_en_a,
  output logic [ADDR_WIDTH-1:0]   bram_addr,
  output logic [2*SAMP_WIDTH-1:0] bram_wr_data,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_WIDTH:0]     count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] ONE_W = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t state;
  logic                  arm_d;
  logic                  arm_pulse;
  logic [ADDR_WIDTH:0]   len_r;
  logic [ADDR_WIDTH:0]   len_eff;
  logic [ADDR_WIDTH:0]   count_inc;

  // Rising edge of the software arm bit; arm_d clears on reset so a level held
  // through reset release still arms once.
  assign arm_pulse = arm & ~arm_d;

  // Zero or anything beyond the buffer depth means "fill the whole buffer".
  assign len_eff = ((num_words == '0) || (num_words > DEPTH_W)) ? DEPTH_W : num_words;

  assign count_inc = count + ONE_W;

  // Port-A enable simply follows the registered write strobe.
  assign bram_en_a = bram_we;

  // Capture FSM with all outputs registered; the write strobe is a one-cycle
  // pulse per accepted sample, address/data hold between writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      arm_d        <= 1'b0;
      len_r        <= '0;
      count        <= '0;
      bram_we      <= 1'b0;
      bram_addr    <= '0;
      bram_wr_data <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      arm_d   <= arm;
      bram_we <= 1'b0;
      case (state)
        IDLE: begin
          // trig is deliberately not looked at here, even with arm_pulse
          if (arm_pulse) begin
            len_r <= len_eff;
            count <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
            state <= ARMED;
          end
        end
        ARMED: begin
          // The triggering sample itself becomes word 0.
          if (trig && din_valid) begin
            bram_we      <= 1'b1;
            bram_addr    <= '0;
            bram_wr_data <= {din_i, din_q};
            count        <= ONE_W;
            state        <= (len_r == ONE_W) ? DONE : CAPTURE;
          end
        end
        CAPTURE: begin
          // Gaps in din_valid just stall; count doubles as the next address.
          if (din_valid) begin
            bram_we      <= 1'b1;
            bram_addr    <= count[ADDR_WIDTH-1:0];
            bram_wr_data <= {din_i, din_q};
            count        <= count_inc;
            if (count_inc == len_r) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          // The cycle after the final write raises done and drops busy.
          if (arm_pulse) begin
            len_r <= len_eff;
            count <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
            state <= ARMED;
          end else begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acc_iq_avg_ss_ctrl.sv
// Randomized bench for the snapshot capture controller: each capture's expected
// write list and BRAM image are built from the stimulus and compared against
// what the DUT writes.
module tb_acc_iq_avg_ss_ctrl;

  localparam int AW    = 10;
  localparam int SW    = 16;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, arm, trig, din_valid;
  logic [AW:0]       num_words;
  logic [SW-1:0]     din_i, din_q;
  logic              bram_we, bram_en_a, busy, done;
  logic [AW-1:0]     bram_addr;
  logic [2*SW-1:0]   bram_wr_data;
  logic [AW:0]       count;

  int checks   = 0;
  int failures = 0;

  logic [AW+2*SW-1:0] wr_q[$];
  logic [AW+2*SW-1:0] exp_q[$];
  logic [2*SW-1:0]    tb_mem[DEPTH];
  logic [2*SW-1:0]    exp_mem[DEPTH];

  acc_iq_avg_ss_ctrl #(.ADDR_WIDTH(AW), .SAMP_WIDTH(SW)) dut (
    .clk          (clk),
    .rst          (rst),
    .arm          (arm),
    .trig         (trig),
    .num_words    (num_words),
    .din_i        (din_i),
    .din_q        (din_q),
    .din_valid    (din_valid),
    .bram_we      (bram_we),
    .bram_en_a    (bram_en_a),
    .bram_addr    (bram_addr),
    .bram_wr_data (bram_wr_data),
    .busy         (busy),
    .done         (done),
    .count        (count)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Port-A observer: records every write and applies it to a model BRAM.
  always @(negedge clk) begin
    if (bram_we === 1'b1 || bram_en_a === 1'b1)
      check_val("en_a_eq_we", bram_en_a, bram_we);
    if (bram_we === 1'b1) begin
      wr_q.push_back({bram_addr, bram_wr_data});
      tb_mem[bram_addr] = bram_wr_data;
      check_val("count_track", count, wr_q.size());
    end
  end

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_we"},   bram_we, 0);
    check_val({tag, "_en"},   bram_en_a, 0);
    check_val({tag, "_addr"}, bram_addr, 0);
    check_val({tag, "_data"}, bram_wr_data, 0);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_done"}, done, 0);
    check_val({tag, "_cnt"},  count, 0);
  endtask

  // vpct: percentage of valid cycles after the trigger, -1 = alternate cycles.
  // pattern: I=k, Q=-k instead of random data. abort_after: reset after that
  // many words (0 = run to completion).
  task automatic run_capture(input int len_in, input int vpct, input bit pattern,
                             input bit trig_at_arm, input int abort_after);
    int L, k, cyc, diffs;
    bit v;
    logic [SW-1:0] di, dq;
    logic [AW-1:0] ka;
    L = (len_in == 0 || len_in > DEPTH) ? DEPTH : len_in;
    wr_q.delete();
    exp_q.delete();
    arm = 1'b0; trig = 1'b0; din_valid = 1'b0;
    num_words = len_in[AW:0];
    @(posedge clk); #1;
    // Arm edge; a coincident trigger+valid must be ignored.
    arm = 1'b1; trig = trig_at_arm; din_valid = trig_at_arm;
    din_i = 16'h7fff; din_q = 16'h0001;
    @(posedge clk); #1;
    num_words = AW'($urandom);
    check_val("armed_busy", busy, 1);
    check_val("armed_done", done, 0);
    check_val("armed_cnt", count, 0);
    // Trigger without valid, then valid without trigger: neither may write.
    trig = 1'b1; din_valid = 1'b0;
    @(posedge clk); #1;
    trig = 1'b0; din_valid = 1'b1;
    @(posedge clk); #1;
    check_val("pre_trig_we", bram_we, 0);
    check_val("pre_trig_writes", wr_q.size(), 0);
    k = 0;
    cyc = 0;
    while (k < L) begin
      if (abort_after > 0 && k == abort_after) break;
      if (k == 0) begin
        v = 1'b1;
        trig = 1'b1;
      end else begin
        check_val("busy_capture", busy, 1);
        v = (vpct < 0) ? ((cyc % 2) == 0) : ($urandom_range(99) < vpct);
        trig = 1'($urandom);
        arm = 1'($urandom);
        num_words = AW'($urandom);
      end
      if (pattern) begin
        di = SW'(k);
        dq = SW'(-k);
      end else begin
        di = SW'($urandom);
        dq = SW'($urandom);
      end
      din_valid = v; din_i = di; din_q = dq;
      if (v) begin
        ka = AW'(k);
        exp_q.push_back({ka, di, dq});
        exp_mem[k] = {di, dq};
        k++;
      end
      cyc++;
      @(posedge clk); #1;
    end
    if (abort_after > 0) begin
      arm = 1'b0; rst = 1'b1; trig = 1'b1; din_valid = 1'b1;
      @(posedge clk); #1;
      check_idle_outputs("abort");
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check_val("abort_busy", busy, 0);
      check_val("abort_writes", wr_q.size(), abort_after);
      trig = 1'b0; din_valid = 1'b0;
    end else begin
      trig = 1'b0; din_valid = 1'b0; arm = 1'b0;
      check_val("last_we", bram_we, 1);
      check_val("last_addr", bram_addr, L - 1);
      check_val("last_cnt", count, L);
      check_val("last_done", done, 0);
      check_val("last_busy", busy, 1);
      @(posedge clk); #1;
      check_val("done_rise", done, 1);
      check_val("done_busy", busy, 0);
      check_val("done_we", bram_we, 0);
      check_val("done_cnt", count, L);
      trig = 1'b1; din_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      trig = 1'b0; din_valid = 1'b0;
      check_val("post_done_writes", wr_q.size(), L);
      check_val("post_done_cnt", count, L);
    end
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
      check_val("write_word", wr_q[i], exp_q[i]);
    diffs = 0;
    for (int i = 0; i < DEPTH; i++)
      if (tb_mem[i] !== exp_mem[i]) diffs++;
    check_val("mem_image", diffs, 0);
    $display("capture len_in=%0d eff=%0d abort=%0d writes=%0d", len_in, L, abort_after, wr_q.size());
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      tb_mem[i]  = '0;
      exp_mem[i] = '0;
    end
    rst = 1'b1; arm = 1'b0; trig = 1'b0; din_valid = 1'b0;
    num_words = '0; din_i = '0; din_q = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs("reset");

    run_capture(8,    100, 1'b1, 1'b0, 0);   // basic I=k, Q=-k
    run_capture(0,    100, 1'b0, 1'b0, 0);   // zero length = full buffer
    run_capture(4,    -1,  1'b0, 1'b0, 0);   // alternate-cycle valid
    run_capture(5,    70,  1'b0, 1'b1, 0);   // trigger coincident with arm edge
    run_capture(2,    100, 1'b0, 1'b0, 0);   // re-arm from done
    run_capture(1,    100, 1'b0, 1'b0, 0);   // single word
    run_capture(1500, 85,  1'b0, 1'b0, 0);   // over-length clamps to full buffer
    run_capture(16,   100, 1'b0, 1'b0, 5);   // reset mid-capture
    run_capture(3,    60,  1'b0, 1'b0, 0);   // restart after reset
    for (int n = 0; n < 6; n++)
      run_capture($urandom_range(40, 1), $urandom_range(100, 30), 1'b0, 1'(n % 2), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
